// File: rtl/brush_stamp_engine.sv
// Stamp engine: turns one dot / square-brush / spray request into a stream of clipped
// canvas pixels, one candidate per cycle, with valid/ready backpressure on the pixel side.
module brush_stamp_engine #(
  parameter int          COORD_W   = 8,
  parameter int          RAD_W     = 2,
  parameter int          SPRAY_N   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic [RAD_W-1:0]   radius,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               busy
);

  localparam int CW = COORD_W + 2;
  localparam logic [CW-1:0]  EIGHT    = {{(CW-4){1'b0}}, 4'd8};
  localparam logic [RAD_W:0] ONE_R    = {{RAD_W{1'b0}}, 1'b1};
  localparam logic [7:0]     LAST_CNT = 8'(SPRAY_N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, STAMP = 2'd1, SPRAY = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [COORD_W-1:0] cx_r, cy_r;
  logic [RAD_W-1:0]   rad_r;
  logic [RAD_W:0]     dx_r, dy_r;
  logic [7:0]         cnt_r;
  logic [15:0]        lfsr_r;

  logic [RAD_W:0]     rad_s;
  logic [RAD_W-1:0]   acc_rad_s;
  logic [RAD_W:0]     acc_neg_s;
  logic [CW-1:0]      off_x_s, off_y_s, cand_x_s, cand_y_s;
  logic               clip_s, step_s, last_s;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // candidate generation, clipping and step/last decode
  always_comb begin
    rad_s     = {1'b0, rad_r};
    acc_rad_s = (mode == 2'd1) ? radius : {RAD_W{1'b0}};
    acc_neg_s = ~{1'b0, acc_rad_s} + ONE_R;
    if (state_r == SPRAY) begin
      off_x_s = {{(CW-4){1'b0}}, lfsr_r[3:0]} - EIGHT;
      off_y_s = {{(CW-4){1'b0}}, lfsr_r[7:4]} - EIGHT;
    end else begin
      off_x_s = {{(CW-RAD_W-1){dx_r[RAD_W]}}, dx_r};
      off_y_s = {{(CW-RAD_W-1){dy_r[RAD_W]}}, dy_r};
    end
    cand_x_s = {2'b00, cx_r} + off_x_s;
    cand_y_s = {2'b00, cy_r} + off_y_s;
    // sign bit flags <0, the next bit flags >2^COORD_W-1
    clip_s   = cand_x_s[CW-1] | cand_x_s[COORD_W] | cand_y_s[CW-1] | cand_y_s[COORD_W];
    step_s   = (state_r != IDLE) && (clip_s || pix_ready);
    case (state_r)
      STAMP:   last_s = (dx_r == rad_s) && (dy_r == rad_s);
      SPRAY:   last_s = (cnt_r == LAST_CNT);
      default: last_s = 1'b0;
    endcase
  end

  // next-state and output decode
  always_comb begin
    state_s   = state_r;
    req_ready = (state_r == IDLE);
    busy      = (state_r != IDLE);
    pix_valid = (state_r != IDLE) && !clip_s;
    pix_x     = pix_valid ? cand_x_s[COORD_W-1:0] : {COORD_W{1'b0}};
    pix_y     = pix_valid ? cand_y_s[COORD_W-1:0] : {COORD_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = (mode == 2'd2) ? SPRAY : STAMP;
        end else begin
          state_s = IDLE;
        end
      end
      STAMP, SPRAY: begin
        if (step_s && last_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // request latch, raster/spray counters and LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cx_r    <= {COORD_W{1'b0}};
      cy_r    <= {COORD_W{1'b0}};
      rad_r   <= {RAD_W{1'b0}};
      dx_r    <= {(RAD_W+1){1'b0}};
      dy_r    <= {(RAD_W+1){1'b0}};
      cnt_r   <= 8'd0;
      lfsr_r  <= LFSR_SEED;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE) begin
        if (req_valid) begin
          cx_r  <= req_x;
          cy_r  <= req_y;
          rad_r <= acc_rad_s;
          dx_r  <= acc_neg_s;
          dy_r  <= acc_neg_s;
          cnt_r <= 8'd0;
        end
      end else if (step_s && !last_s && state_r == STAMP) begin
        if (dx_r == rad_s) begin
          dx_r <= ~rad_s + ONE_R;
          dy_r <= dy_r + ONE_R;
        end else begin
          dx_r <= dx_r + ONE_R;
        end
      end else if (step_s && state_r == SPRAY) begin
        cnt_r  <= cnt_r + 8'd1;
        lfsr_r <= lfsr_next(lfsr_r);
      end
    end
  end

endmodule

// File: tb/tb_brush_stamp_engine.sv
// Directed bench: stimulus pushes expected pixels into a queue, an independent monitor
// pops and compares on every pixel handshake and checks stability under backpressure.
module tb_brush_stamp_engine;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, req_ready, pix_valid, pix_ready, busy;
  logic [1:0] mode, radius;
  logic [7:0] req_x, req_y, pix_x, pix_y;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  brush_stamp_engine #(.COORD_W(8), .RAD_W(2), .SPRAY_N(4), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .mode(mode),
    .req_x(req_x), .req_y(req_y), .radius(radius), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int x, input int y);
    exp_q.push_back({8'(x), 8'(y)});
  endtask

  // monitor: pops expected pixel on each handshake, checks hold while stalled
  initial begin
    logic       pv;
    logic [7:0] px, py;
    logic [15:0] e;
    pv = 1'b0; px = 8'd0; py = 8'd0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          check("hold_valid", 32'(pix_valid), 32'd1);
          check("hold_xy", 32'({pix_x, pix_y}), 32'({px, py}));
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pix_x, pix_y);
          end else begin
            e = exp_q.pop_front();
            check("pixel_xy", 32'({pix_x, pix_y}), 32'(e));
          end
        end
        pv = pix_valid && !pix_ready;
        px = pix_x; py = pix_y;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic [1:0] m, input int x, input int y, input int r,
                        input int stall_idx, input int stall_len,
                        output int busy_n, output int pix_n, output int first_v);
    int k, left;
    @(negedge clk);
    req_valid = 1'b1; mode = m; req_x = 8'(x); req_y = 8'(y); radius = 2'(r);
    pix_ready = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; mode = 2'd1; req_x = 8'hA5; req_y = 8'h5A; radius = 2'd3;
    busy_n = 0; pix_n = 0; first_v = -1; left = stall_len;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!busy) break;
      busy_n++;
      if (pix_valid) begin
        if (first_v < 0) first_v = c;
        if (pix_n == stall_idx && left > 0) begin
          pix_ready = 1'b0;
          left--;
        end else begin
          pix_ready = 1'b1;
          pix_n++;
        end
      end else begin
        pix_ready = 1'b1;
      end
    end
    check("busy_done", 32'(busy), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int b, p, f;
    rst_n = 1'b0; req_valid = 1'b0; pix_ready = 1'b1;
    mode = 2'd0; req_x = 8'd0; req_y = 8'd0; radius = 2'd0;
    #12;
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_xy", 32'({pix_x, pix_y}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // dot at (10,20)
    push(10, 20);
    do_req(2'd0, 10, 20, 2, -1, 0, b, p, f);
    check("dot_busy", 32'(b), 32'd1);
    check("dot_pix", 32'(p), 32'd1);
    check("dot_first", 32'(f), 32'd1);

    // mode 3 is a dot regardless of radius
    push(7, 9);
    do_req(2'd3, 7, 9, 3, -1, 0, b, p, f);
    check("dot3_busy", 32'(b), 32'd1);

    // square r=1 at (5,5)
    for (int dy = -1; dy <= 1; dy++) for (int dx = -1; dx <= 1; dx++) push(5 + dx, 5 + dy);
    do_req(2'd1, 5, 5, 1, -1, 0, b, p, f);
    check("sq_busy", 32'(b), 32'd9);
    check("sq_pix", 32'(p), 32'd9);
    check("sq_first", 32'(f), 32'd1);

    // same square with a 3-cycle stall on the 2nd pixel
    for (int dy = -1; dy <= 1; dy++) for (int dx = -1; dx <= 1; dx++) push(5 + dx, 5 + dy);
    do_req(2'd1, 5, 5, 1, 1, 3, b, p, f);
    check("bp_busy", 32'(b), 32'd12);
    check("bp_pix", 32'(p), 32'd9);

    // corner (0,0): 4 pixels, 5 clipped
    push(0, 0); push(1, 0); push(0, 1); push(1, 1);
    do_req(2'd1, 0, 0, 1, -1, 0, b, p, f);
    check("c0_busy", 32'(b), 32'd9);
    check("c0_pix", 32'(p), 32'd4);
    check("c0_first", 32'(f), 32'd5);

    // corner (255,255): no wrap
    push(254, 254); push(255, 254); push(254, 255); push(255, 255);
    do_req(2'd1, 255, 255, 1, -1, 0, b, p, f);
    check("c255_busy", 32'(b), 32'd9);
    check("c255_pix", 32'(p), 32'd4);

    // r=2 at (1,254): x clipped at -1, y clipped at 256
    for (int dy = -2; dy <= 2; dy++)
      for (int dx = -2; dx <= 2; dx++)
        if (1 + dx >= 0 && 254 + dy <= 255) push(1 + dx, 254 + dy);
    do_req(2'd1, 1, 254, 2, -1, 0, b, p, f);
    check("r2_busy", 32'(b), 32'd25);
    check("r2_pix", 32'(p), 32'd16);

    // reset mid-square
    for (int dy = -1; dy <= 1; dy++) for (int dx = -1; dx <= 1; dx++) push(5 + dx, 5 + dy);
    @(negedge clk);
    req_valid = 1'b1; mode = 2'd1; req_x = 8'd5; req_y = 8'd5; radius = 2'd1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_xy", 32'({pix_x, pix_y}), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      if (i == 0 || i == 7) begin
        check("post_rst_valid", 32'(pix_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
      end
    end

    // spray continues LFSR from seed after reset
    push(93, 106); push(92, 99); push(100, 95); push(104, 101);
    do_req(2'd2, 100, 100, 0, -1, 0, b, p, f);
    check("spray1_busy", 32'(b), 32'd4);
    check("spray1_first", 32'(f), 32'd1);

    push(106, 96); push(99, 94); push(95, 93); push(101, 100);
    do_req(2'd2, 100, 100, 0, -1, 0, b, p, f);
    check("spray2_busy", 32'(b), 32'd4);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
